mem_access_ctrl: RTL and testbench

- Sequences the MEM-stage data-memory access for the 5-stage pipeline over a variable-latency req/ack memory port.
- Sits between the EXE→MEM pipeline register outputs and the MEM→WB register.
- Generates the pipeline-wide freeze that holds the PC, IF/ID, ID/EXE and EXE/MEM registers while an access is outstanding.
- Inserts a bubble into MEM→WB during a stall and flags bus timeouts and misaligned or illegal accesses.

---
 rtl/mem_ctrl_pkg.sv | 23 ++
 rtl/mem_timeout_cnt.sv | 34 +++
 rtl/mem_access_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the MEM-stage access controller: FSM state encoding,
// error codes and the alignment helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE     = 2'd0;
  localparam err_code_t ERR_TIMEOUT  = 2'd1;
  localparam err_code_t ERR_MISALIGN = 2'd2;
  localparam err_code_t ERR_ILLEGAL  = 2'd3;

  // Word accesses only: any nonzero byte offset is a fault.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts BUSY cycles of an outstanding memory access; expired flags the last
// allowed wait cycle. A zero limit disables expiry.
module mem_timeout_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] count_r;

  // Wait-cycle counter: clear on request issue, step each unacknowledged cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= CNT_ZERO;
    end else if (clear) begin
      count_r <= CNT_ZERO;
    end else if (enable) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (limit != CNT_ZERO) && (count_r == (limit - CNT_ONE));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues one req/ack transaction per load or
// store, freezes the upstream pipeline while it is outstanding, flags faults.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic              wb_en_in,
  input  logic [ADDR_W-1:0] alu_res,
  input  logic [DATA_W-1:0] st_val,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              freeze,
  output logic              wb_en_out,
  output logic              err_timeout,
  output logic              err_misalign,
  output logic              err_illegal
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT);

  state_t            state_r;
  state_t            state_next_s;
  err_code_t         err_code_s;
  logic              access_s;
  logic              misalign_s;
  logic              illegal_s;
  logic              freeze_s;
  logic              issue_s;
  logic              ack_done_s;
  logic              timeout_s;
  logic              misalign_done_s;
  logic              cnt_clear_s;
  logic              cnt_en_s;
  logic              cnt_expired_s;

  logic              mem_req_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              err_timeout_r;
  logic              err_misalign_r;
  logic              err_illegal_r;

  assign access_s   = mem_r_en | mem_w_en;
  assign misalign_s = access_s & is_misaligned(alu_res[1:0]);
  assign illegal_s  = mem_r_en & mem_w_en;

  mem_timeout_cnt #(
    .CNT_W (CNT_W)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear_s),
    .enable  (cnt_en_s),
    .limit   (TIMEOUT_LIM),
    .expired (cnt_expired_s)
  );

  // Next-state, freeze and datapath strobes; an ack on the last wait cycle beats the timeout.
  always_comb begin
    state_next_s    = state_r;
    freeze_s        = 1'b0;
    issue_s         = 1'b0;
    ack_done_s      = 1'b0;
    timeout_s       = 1'b0;
    misalign_done_s = 1'b0;
    cnt_clear_s     = 1'b0;
    cnt_en_s        = 1'b0;
    err_code_s      = ERR_NONE;
    case (state_r)
      IDLE: begin
        if (access_s) begin
          freeze_s = 1'b1;
          if (misalign_s) begin
            state_next_s    = DONE;
            misalign_done_s = 1'b1;
            err_code_s      = ERR_MISALIGN;
          end else begin
            state_next_s = BUSY;
            issue_s      = 1'b1;
            cnt_clear_s  = 1'b1;
            if (illegal_s) begin
              err_code_s = ERR_ILLEGAL;
            end else begin
              err_code_s = ERR_NONE;
            end
          end
        end else begin
          freeze_s = 1'b0;
        end
      end
      BUSY: begin
        freeze_s = 1'b1;
        if (mem_ack) begin
          state_next_s = DONE;
          ack_done_s   = 1'b1;
        end else if (cnt_expired_s) begin
          state_next_s = DONE;
          timeout_s    = 1'b1;
          err_code_s   = ERR_TIMEOUT;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request, load-result and error-pulse registers; the error code decodes to one flag at most.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_r      <= 1'b0;
      mem_we_r       <= 1'b0;
      mem_addr_r     <= {ADDR_W{1'b0}};
      mem_wdata_r    <= {DATA_W{1'b0}};
      rdata_r        <= {DATA_W{1'b0}};
      err_timeout_r  <= 1'b0;
      err_misalign_r <= 1'b0;
      err_illegal_r  <= 1'b0;
    end else begin
      if (issue_s) begin
        mem_req_r   <= 1'b1;
        mem_we_r    <= mem_w_en;
        mem_addr_r  <= alu_res;
        mem_wdata_r <= st_val;
      end else if (ack_done_s | timeout_s) begin
        mem_req_r <= 1'b0;
      end
      if (ack_done_s & ~mem_we_r) begin
        rdata_r <= mem_rdata;
      end else if (timeout_s | misalign_done_s) begin
        rdata_r <= {DATA_W{1'b0}};
      end
      err_timeout_r  <= (err_code_s == ERR_TIMEOUT);
      err_misalign_r <= (err_code_s == ERR_MISALIGN);
      err_illegal_r  <= (err_code_s == ERR_ILLEGAL);
    end
  end

  assign mem_req      = mem_req_r;
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign rdata        = rdata_r;
  assign freeze       = freeze_s;
  assign wb_en_out    = wb_en_in & ~freeze_s;
  assign err_timeout  = err_timeout_r;
  assign err_misalign = err_misalign_r;
  assign err_illegal  = err_illegal_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: scenario tasks push expected
// transaction results to a queue and pop them when the access reaches DONE.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst, mem_r_en, mem_w_en, wb_en_in, mem_ack, sel_to;
  logic [31:0] alu_res, st_val, mem_rdata;

  logic        mem_req_a, mem_we_a, freeze_a, wb_en_out_a, err_timeout_a, err_misalign_a, err_illegal_a;
  logic [31:0] mem_addr_a, mem_wdata_a, rdata_a;
  logic        mem_req_t, mem_we_t, freeze_t, wb_en_out_t, err_timeout_t, err_misalign_t, err_illegal_t;
  logic [31:0] mem_addr_t, mem_wdata_t, rdata_t;

  logic        o_req, o_we, o_freeze, o_wb, o_e_to, o_e_mis, o_e_ill;
  logic [31:0] o_addr, o_wdata, o_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en_in(wb_en_in),
    .alu_res(alu_res), .st_val(st_val), .mem_req(mem_req_a), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rdata(rdata_a), .freeze(freeze_a), .wb_en_out(wb_en_out_a), .err_timeout(err_timeout_a),
    .err_misalign(err_misalign_a), .err_illegal(err_illegal_a)
  );

  mem_access_ctrl #(.TIMEOUT(3)) dut_to (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en_in(wb_en_in),
    .alu_res(alu_res), .st_val(st_val), .mem_req(mem_req_t), .mem_we(mem_we_t),
    .mem_addr(mem_addr_t), .mem_wdata(mem_wdata_t), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rdata(rdata_t), .freeze(freeze_t), .wb_en_out(wb_en_out_t), .err_timeout(err_timeout_t),
    .err_misalign(err_misalign_t), .err_illegal(err_illegal_t)
  );

  assign o_req    = sel_to ? mem_req_t      : mem_req_a;
  assign o_we     = sel_to ? mem_we_t       : mem_we_a;
  assign o_addr   = sel_to ? mem_addr_t     : mem_addr_a;
  assign o_wdata  = sel_to ? mem_wdata_t    : mem_wdata_a;
  assign o_rdata  = sel_to ? rdata_t        : rdata_a;
  assign o_freeze = sel_to ? freeze_t       : freeze_a;
  assign o_wb     = sel_to ? wb_en_out_t    : wb_en_out_a;
  assign o_e_to   = sel_to ? err_timeout_t  : err_timeout_a;
  assign o_e_mis  = sel_to ? err_misalign_t : err_misalign_a;
  assign o_e_ill  = sel_to ? err_illegal_t  : err_illegal_a;

  // errs bit order: {timeout, misalign, illegal}
  typedef struct {
    logic [31:0] rdata;
    int          req_cyc;
    int          frz_cyc;
    logic [2:0]  errs;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    int          req_cyc;
    int          frz_cyc;
    logic [2:0]  errs;
    int          err_total;
    int          hold_bad;
    int          wb_bad;
    logic        wb_done;
    logic        timed_out;
  } obs_t;

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdat;
    int          ack_wait;
  } stim_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic do_reset;
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives one access and records what the selected DUT did up to its DONE cycle.
  task automatic run_txn(input stim_t s, output obs_t o);
    int   busy_idx;
    logic done;
    o.rdata = 32'h0; o.req_cyc = 0; o.frz_cyc = 0; o.errs = 3'b000; o.err_total = 0;
    o.hold_bad = 0; o.wb_bad = 0; o.wb_done = 1'b0; o.timed_out = 1'b0;
    busy_idx = 0;
    done = 1'b0;
    @(posedge clk);
    #1;
    mem_r_en = s.r; mem_w_en = s.w; alu_res = s.addr; st_val = s.wdata; wb_en_in = 1'b1;
    mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      o.err_total += int'(o_e_to) + int'(o_e_mis) + int'(o_e_ill);
      if (o_freeze) begin
        o.frz_cyc++;
        if (o_wb) o.wb_bad++;
        if (o_req) begin
          if (busy_idx == 0) o.errs[0] = o_e_ill;
          o.req_cyc++;
          if ({o_we, o_addr, o_wdata} !== {s.w, s.addr, s.wdata}) o.hold_bad++;
          if (busy_idx == s.ack_wait) begin
            mem_ack = 1'b1; mem_rdata = s.rdat;
          end else begin
            mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
          end
          busy_idx++;
        end
      end else if (o.frz_cyc > 0) begin
        done = 1'b1;
        o.rdata = o_rdata; o.wb_done = o_wb; o.errs[2] = o_e_to; o.errs[1] = o_e_mis;
        mem_r_en = 1'b0; mem_w_en = 1'b0; wb_en_in = 1'b0; mem_ack = 1'b0;
      end
    end
    o.timed_out = !done;
    if (!done) begin
      mem_r_en = 1'b0; mem_w_en = 1'b0; wb_en_in = 1'b0; mem_ack = 1'b0;
    end
  endtask

  task automatic test_reset;
    wb_en_in = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({o_req, o_we, o_addr, o_wdata, o_rdata} !== 67'h0) begin
      n_err++; $display("FAIL reset_regs: req=%b we=%b addr=%h wdata=%h rdata=%h, expected all 0",
                        o_req, o_we, o_addr, o_wdata, o_rdata);
    end
    n_vec++;
    if ({o_e_to, o_e_mis, o_e_ill, o_freeze, o_wb} !== 5'b00001) begin
      n_err++; $display("FAIL reset_flags: errs/freeze/wb=%b, expected 00001",
                        {o_e_to, o_e_mis, o_e_ill, o_freeze, o_wb});
    end
    n_vec++;
    if ({mem_req_t, rdata_t, freeze_t} !== 34'h0) begin
      n_err++; $display("FAIL reset_to_dut: req=%b rdata=%h freeze=%b, expected 0", mem_req_t, rdata_t, freeze_t);
    end
  endtask

  // Runs a table of accesses; expected results are queued first, popped at each DONE.
  task automatic run_table(input string name, input stim_t st[], input exp_t ex[]);
    obs_t o;
    exp_t e;
    foreach (ex[i]) exp_q.push_back(ex[i]);
    foreach (st[i]) begin
      run_txn(st[i], o);
      e = exp_q.pop_front();
      n_vec++;
      if (o.timed_out !== 1'b0) begin
        n_err++; $display("FAIL %s[%0d]_done: no DONE within 40 cycles, expected DONE", name, i);
      end
      n_vec++;
      if (o.req_cyc != e.req_cyc || o.frz_cyc != e.frz_cyc) begin
        n_err++; $display("FAIL %s[%0d]_cycles: req=%0d freeze=%0d, expected req=%0d freeze=%0d",
                          name, i, o.req_cyc, o.frz_cyc, e.req_cyc, e.frz_cyc);
      end
      n_vec++;
      if (o.rdata !== e.rdata) begin
        n_err++; $display("FAIL %s[%0d]_rdata: got %h, expected %h", name, i, o.rdata, e.rdata);
      end
      n_vec++;
      if (o.errs !== e.errs || o.err_total != $countones(e.errs)) begin
        n_err++; $display("FAIL %s[%0d]_err: flags=%b pulses=%0d, expected flags=%b pulses=%0d",
                          name, i, o.errs, o.err_total, e.errs, $countones(e.errs));
      end
      n_vec++;
      if (o.hold_bad != 0 || o.wb_bad != 0 || o.wb_done !== 1'b1) begin
        n_err++; $display("FAIL %s[%0d]_hold_wb: hold_bad=%0d wb_bad=%0d wb_done=%b, expected 0 0 1",
                          name, i, o.hold_bad, o.wb_bad, o.wb_done);
      end
    end
  endtask

  task automatic test_load;
    run_table("load", '{'{1'b1, 1'b0, 32'h10, 32'h0, 32'hCAFE_F00D, 0}},
              '{'{32'hCAFE_F00D, 1, 2, 3'b000}});
  endtask

  task automatic test_store;
    run_table("store", '{'{1'b0, 1'b1, 32'h20, 32'h1234_5678, 32'h0BAD_0BAD, 4}},
              '{'{32'hCAFE_F00D, 5, 6, 3'b000}});
  endtask

  task automatic test_misalign;
    run_table("misalign", '{'{1'b1, 1'b0, 32'h13, 32'h0, 32'h0BAD_0BAD, 0},
                            '{1'b0, 1'b1, 32'h22, 32'h0000_0022, 32'h0BAD_0BAD, 0}},
              '{'{32'h0, 0, 1, 3'b010}, '{32'h0, 0, 1, 3'b010}});
  endtask

  task automatic test_illegal;
    run_table("illegal", '{'{1'b1, 1'b1, 32'h40, 32'h0BAD_0040, 32'hFFFF_0000, 0}},
              '{'{32'h0, 1, 2, 3'b001}});
  endtask

  task automatic test_back_to_back;
    run_table("b2b", '{'{1'b1, 1'b0, 32'h100, 32'h0, 32'hA5A5_0001, 2},
                       '{1'b0, 1'b1, 32'h104, 32'h0000_BEEF, 32'h0BAD_0BAD, 1},
                       '{1'b1, 1'b0, 32'h108, 32'h0, 32'h600D_0003, 0}},
              '{'{32'hA5A5_0001, 3, 4, 3'b000}, '{32'hA5A5_0001, 2, 3, 3'b000},
                '{32'h600D_0003, 1, 2, 3'b000}});
  endtask

  task automatic test_stray_ack;
    @(posedge clk);
    #1 mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if ({o_req, o_freeze, o_e_to, o_e_mis, o_e_ill} !== 5'b0 || o_rdata !== 32'h600D_0003) begin
        n_err++; $display("FAIL stray_ack[%0d]: req=%b freeze=%b rdata=%h, expected 0 0 600d0003",
                          c, o_req, o_freeze, o_rdata);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_timeout;
    sel_to = 1'b1;
    do_reset();
    run_table("timeout", '{'{1'b1, 1'b0, 32'h30, 32'h0, 32'h5555_AAAA, 1},
                           '{1'b1, 1'b0, 32'h34, 32'h0, 32'h0BAD_0BAD, -1}},
              '{'{32'h5555_AAAA, 2, 3, 3'b000}, '{32'h0, 3, 4, 3'b100}});
    sel_to = 1'b0;
  endtask

  task automatic test_reset_mid_busy;
    do_reset();
    run_table("pre_rst", '{'{1'b1, 1'b0, 32'h50, 32'h0, 32'h7777_0001, 0}},
              '{'{32'h7777_0001, 1, 2, 3'b000}});
    @(posedge clk);
    #1 mem_r_en = 1'b1; alu_res = 32'h44; st_val = 32'h4444_5555; wb_en_in = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (o_req !== 1'b1) begin
      n_err++; $display("FAIL rst_busy_req: mem_req=%b, expected 1", o_req);
    end
    @(negedge clk);
    rst = 1'b1; mem_r_en = 1'b0; wb_en_in = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({o_req, o_we, o_addr, o_wdata, o_rdata, o_freeze, o_e_to, o_e_mis, o_e_ill} !== 100'h0) begin
      n_err++; $display("FAIL rst_busy_clear: req=%b we=%b addr=%h wdata=%h rdata=%h freeze=%b, expected all 0",
                        o_req, o_we, o_addr, o_wdata, o_rdata, o_freeze);
    end
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
    @(negedge clk);
    n_vec++;
    if ({o_req, o_freeze, o_e_to, o_e_mis, o_e_ill} !== 5'b0 || o_rdata !== 32'h0) begin
      n_err++; $display("FAIL rst_late_ack: req=%b freeze=%b rdata=%h, expected 0 0 0", o_req, o_freeze, o_rdata);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    sel_to = 1'b0; wb_en_in = 1'b0; alu_res = 32'h0; st_val = 32'h0; mem_rdata = 32'h0;
    do_reset();
    test_reset();
    test_load();
    test_store();
    test_misalign();
    test_illegal();
    test_back_to_back();
    test_stray_ack();
    test_timeout();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units, expected completion");
    $fatal(1);
  end

endmodule
